mips_soc: RTL and testbench
===========================

Name: mips_soc

Overview:
- FPGA top of the P8 MIPS system.
- Instantiates the existing pipelined core `mips_core` (instance CPU) and implements the system bridge plus memory-mapped peripherals: DIP switches, user keys, LEDs, 7-segment tubes and a UART.
- Board pins are routed straight to its ports; the core sees a single 32-bit load/store bus.

Parameters:
CLK_FREQ, 25_000_000, clk_in frequency in Hz
BAUD, 9600, UART bit rate; bit period = CLK_FREQ/BAUD cycles
SCAN_HZ, 1000, tube digit-scan rate

Ports:
clk_in  input  1  system clock, all logic on rising edge
sys_rstn  input  1  asynchronous active-low reset
dip_switch0..dip_switch7  input  8 each  raw switches
user_key  input  8  raw keys, active-high
uart_rxd  input  1  UART receive line
digital_tube_sel0  output  4  one-hot digit select, tube group 0
digital_tube_sel1  output  4  one-hot digit select, tube group 1
digital_tube_sel2  output  1  select, single tube
digital_tube0/1/2  output  8 each  segments {dp,g..a}, active-low
led_light  output  32  LEDs, active-low
uart_txd  output  1  UART transmit line, idle high

Behaviour:
- One clock domain, clk_in. Reset is asynchronous and active-low on sys_rstn.
- sys_rstn is synchronised: assertion is asynchronous, deassertion is synchronous through 2 flops.
- All inputs pass through 2-FF synchronisers; reads see the synchronised values.
- Bridge maps the core's word address/wdata/we/rdata; accesses are word only. Decode on addr[15:0]:
  - 0x7F10 UART data: write starts TX of wdata[7:0]; read returns the RX byte and clears rx_valid.
  - 0x7F14 UART status: bit0 tx_ready, bit1 rx_valid; read-only.
  - 0x7F2C read {dip_switch3,dip_switch2,dip_switch1,dip_switch0}.
  - 0x7F30 read {dip_switch7..dip_switch4}.
  - 0x7F34 read {24'b0,user_key}.
  - 0x7F38 tube_reg (R/W, 32 bits).
  - 0x7F3C tube2_reg (R/W, low 4 bits).
  - 0x7F40 led_reg (R/W, 32 bits).
  - Unmapped addresses read 0; writes to them are ignored.
  - Peripheral writes take effect on the same clock edge as core write-enable. Read data is combinational.
- Register outputs and reset values:
  - led_light = ~led_reg; reset led_reg=0, so all LEDs are off (0xFFFFFFFF).
  - tube_reg and tube2_reg reset to 0, so every tube shows "0".
- Tube scan:
  - Counter of CLK_FREQ/SCAN_HZ cycles advances a 2-bit digit index, wrapping 3->0.
  - Group 0 shows tube_reg[15:0] and group 1 shows tube_reg[31:16]; digit i shows nibble i.
  - sel outputs are one-hot active-high, sel0=sel1=1<<i. sel2 is constantly 1 and shows tube2_reg.
  - Hex 0-F encoding, dp off.
- UART: 8N1.
  - TX: write while busy is dropped. tx_ready=0 from the write until the stop bit ends.
  - RX: start-bit edge, then sample at mid-bit. A new byte overwrites an unread one. A bad stop bit discards the byte.
- Interrupts to core: HWInt[2]=rx_valid; HWInt[3]=OR of user_key, level-sensitive; other bits 0.
- Reset mid-frame aborts TX/RX immediately; uart_txd returns high.

Optional Feature:
- MIPS_WB_TRACE_EN
- Defined:
  - Every cycle the core's GRF write-enable is high and A3≠0, print "@%h:%d <= %h".
  - Fields are PC (= WB-stage PC8 − 8), destination register, write data.
  - Simulation-only, non-synthesised.
- Undefined: no trace logic; core trace pins are left unconnected.

Decomposition:
- Package mips_soc_pkg holds address constants, the UART status bit indices and the hex-to-segment function.
- Natural sub-module: uart_8n1 (TX+RX, parameterised by bit period).
- Bridge, GPIO and tube scanner stay inline.

Test Plan:
- Reset: hold sys_rstn=0 → led_light=0xFFFFFFFF, uart_txd=1, digital_tube0 = "0" pattern 8'hC0.
- Switches: set dip 0-3 word=0x00000001, dip 4-7 word=0x00000001; core loads 0x7F2C and 0x7F30 → both return 1; trace prints the $t register write with value 00000001.
- Keys: user_key=8'h01 → read 0x7F34 returns 0x00000001 and HWInt[3]=1 within 2 cycles.
- LEDs: store 0x0000000F to 0x7F40 → led_light=0xFFFFFFF0 next cycle; read-back returns 0x0F.
- Tubes: store 0x12345678 to 0x7F38 → over 4 scan periods, sel0 steps 0001,0010,0100,1000 showing 8,7,6,5; sel1 shows 4,3,2,1.
- UART: store 0x55 to 0x7F10 → txd start bit, 10101010 LSB-first, stop bit, each CLK_FREQ/BAUD cycles long; inject 0xA3 on rxd → status bit1=1, data read=0xA3, bit1 clears.

Source files
------------

// File: rtl/mips_soc_pkg.sv
// Shared constants for the P8 MIPS SoC: bus address map, UART status bits,
// UART state encoding and the hex-to-7-segment decoder.
package mips_soc_pkg;

    localparam logic [15:0] ADDR_UART_DATA = 16'h7F10;
    localparam logic [15:0] ADDR_UART_STAT = 16'h7F14;
    localparam logic [15:0] ADDR_DIP_LO    = 16'h7F2C;
    localparam logic [15:0] ADDR_DIP_HI    = 16'h7F30;
    localparam logic [15:0] ADDR_KEY       = 16'h7F34;
    localparam logic [15:0] ADDR_TUBE      = 16'h7F38;
    localparam logic [15:0] ADDR_TUBE2     = 16'h7F3C;
    localparam logic [15:0] ADDR_LED       = 16'h7F40;

    localparam int STAT_TX_READY = 0;
    localparam int STAT_RX_VALID = 1;

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

    // Segments {dp,g,f,e,d,c,b,a}, active-low, dp always off.
    function automatic logic [7:0] hex_seg(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mips_core.sv
// Interface shell of the pipelined P8 core: presents an idle load/store bus.
// The full build substitutes the real core; MIPS_WB_TRACE_EN adds the GRF trace pins.
module mips_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  hw_int,
    input  logic [31:0] pr_rd,
    output logic [31:0] pr_addr,
    output logic [31:0] pr_wd,
    output logic        pr_we
`ifdef MIPS_WB_TRACE_EN
    ,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] wb_pc8
`endif
);
    assign pr_addr = '0;
    assign pr_wd   = '0;
    assign pr_we   = 1'b0;
`ifdef MIPS_WB_TRACE_EN
    assign grf_we = 1'b0;
    assign grf_a3 = '0;
    assign grf_wd = '0;
    assign wb_pc8 = '0;
`endif

    logic unused_ok;
    assign unused_ok = ^{clk, reset, hw_int, pr_rd};
endmodule

// File: rtl/mips_soc_uart.sv
// 8N1 UART: TX shifter and mid-bit sampling RX, BIT_CYCLES clocks per bit.
// rxd must already be synchronised to clk.
module uart_8n1 import mips_soc_pkg::*; #(
    parameter int BIT_CYCLES = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       txd,
    input  logic       rxd,
    input  logic       rx_read,
    output logic [7:0] rx_data,
    output logic       rx_valid
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] FULL = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);

    uart_state_t   tx_state, tx_next, rx_state, rx_next;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [2:0]    tx_idx, rx_idx;
    logic [7:0]    tx_sh, rx_sh;
    logic          tx_tick, rx_tick, rx_half;

    assign tx_tick = (tx_cnt == FULL);
    assign rx_tick = (rx_cnt == FULL);
    assign rx_half = (rx_cnt == HALF);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tx_state <= U_IDLE;
            rx_state <= U_IDLE;
        end else begin
            tx_state <= tx_next;
            rx_state <= rx_next;
        end

    // A start request outside IDLE is simply ignored; RX re-checks the start bit at mid-bit.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            U_IDLE:  if (tx_start) tx_next = U_START;
            U_START: if (tx_tick) tx_next = U_DATA;
            U_DATA:  if (tx_tick && tx_idx == 3'd7) tx_next = U_STOP;
            U_STOP:  if (tx_tick) tx_next = U_IDLE;
            default: tx_next = U_IDLE;
        endcase
        rx_next = rx_state;
        case (rx_state)
            U_IDLE:  if (!rxd) rx_next = U_START;
            U_START: if (rx_half) rx_next = rxd ? U_IDLE : U_DATA;
            U_DATA:  if (rx_tick && rx_idx == 3'd7) rx_next = U_STOP;
            U_STOP:  if (rx_tick) rx_next = U_IDLE;
            default: rx_next = U_IDLE;
        endcase
    end

    always_comb begin
        txd      = 1'b1;
        tx_ready = 1'b0;
        case (tx_state)
            U_IDLE:  tx_ready = 1'b1;
            U_START: txd = 1'b0;
            U_DATA:  txd = tx_sh[0];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tx_cnt <= '0;
            tx_idx <= '0;
            tx_sh  <= '0;
        end else begin
            tx_cnt <= (tx_state == U_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
            if (tx_state == U_IDLE && tx_start) begin
                tx_sh  <= tx_data;
                tx_idx <= '0;
            end else if (tx_state == U_DATA && tx_tick) begin
                tx_sh  <= tx_sh >> 1;
                tx_idx <= tx_idx + 1'b1;
            end
        end

    // A good stop bit publishes the byte, overwriting any unread one.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_cnt <= (rx_state != rx_next || rx_tick) ? '0 : rx_cnt + 1'b1;
            if (rx_state == U_START)
                rx_idx <= '0;
            else if (rx_state == U_DATA && rx_tick) begin
                rx_sh  <= {rxd, rx_sh[7:1]};
                rx_idx <= rx_idx + 1'b1;
            end
            if (rx_state == U_STOP && rx_tick && rxd) begin
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
            end else if (rx_read)
                rx_valid <= 1'b0;
        end
endmodule

// File: rtl/mips_soc.sv
// FPGA top of the P8 MIPS system: core, bus bridge, GPIO, tube scanner and UART.
// Define MIPS_WB_TRACE_EN for a simulation-only print of every GRF write-back.
module mips_soc import mips_soc_pkg::*; #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 9600,
    parameter int SCAN_HZ  = 1000
) (
    input  logic        clk_in,
    input  logic        sys_rstn,
    input  logic [7:0]  dip_switch0,
    input  logic [7:0]  dip_switch1,
    input  logic [7:0]  dip_switch2,
    input  logic [7:0]  dip_switch3,
    input  logic [7:0]  dip_switch4,
    input  logic [7:0]  dip_switch5,
    input  logic [7:0]  dip_switch6,
    input  logic [7:0]  dip_switch7,
    input  logic [7:0]  user_key,
    input  logic        uart_rxd,
    output logic [3:0]  digital_tube_sel0,
    output logic [3:0]  digital_tube_sel1,
    output logic        digital_tube_sel2,
    output logic [7:0]  digital_tube0,
    output logic [7:0]  digital_tube1,
    output logic [7:0]  digital_tube2,
    output logic [31:0] led_light,
    output logic        uart_txd
);
    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int SCAN_DIV   = CLK_FREQ / SCAN_HZ;
    localparam int SW         = $clog2(SCAN_DIV);

    logic [1:0] rst_sync;
    logic       rst_n;
    always_ff @(posedge clk_in or negedge sys_rstn)
        if (!sys_rstn) rst_sync <= '0;
        else           rst_sync <= {rst_sync[0], 1'b1};
    assign rst_n = rst_sync[1];

    logic [63:0] dip_m, dip_s;
    logic [7:0]  key_m, key_s;
    logic        rxd_m, rxd_s;
    always_ff @(posedge clk_in or negedge rst_n)
        if (!rst_n) begin
            dip_m <= '0;  dip_s <= '0;
            key_m <= '0;  key_s <= '0;
            rxd_m <= 1'b1; rxd_s <= 1'b1;
        end else begin
            dip_m <= {dip_switch7, dip_switch6, dip_switch5, dip_switch4,
                      dip_switch3, dip_switch2, dip_switch1, dip_switch0};
            dip_s <= dip_m;
            key_m <= user_key;  key_s <= key_m;
            rxd_m <= uart_rxd;  rxd_s <= rxd_m;
        end

    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_we;
    logic [5:0]  hw_int;
    logic [15:0] addr;
    assign addr = cpu_addr[15:0];

`ifdef MIPS_WB_TRACE_EN
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, wb_pc8;
    always @(posedge clk_in)
        if (grf_we && grf_a3 != 5'd0)
            $display("@%h:%d <= %h", wb_pc8 - 32'd8, grf_a3, grf_wd);
`endif

    mips_core CPU (
        .clk     (clk_in),
        .reset   (!rst_n),
        .hw_int  (hw_int),
        .pr_rd   (cpu_rdata),
        .pr_addr (cpu_addr),
        .pr_wd   (cpu_wdata),
        .pr_we   (cpu_we)
`ifdef MIPS_WB_TRACE_EN
        ,
        .grf_we  (grf_we),
        .grf_a3  (grf_a3),
        .grf_wd  (grf_wd),
        .wb_pc8  (wb_pc8)
`endif
    );

    logic       tx_ready, rx_valid;
    logic [7:0] rx_data;
    uart_8n1 #(.BIT_CYCLES(BIT_CYCLES)) uart (
        .clk      (clk_in),
        .rst_n    (rst_n),
        .tx_start (cpu_we && addr == ADDR_UART_DATA),
        .tx_data  (cpu_wdata[7:0]),
        .tx_ready (tx_ready),
        .txd      (uart_txd),
        .rxd      (rxd_s),
        .rx_read  (!cpu_we && addr == ADDR_UART_DATA),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    logic [31:0] led_reg, tube_reg;
    logic [3:0]  tube2_reg;
    always_ff @(posedge clk_in or negedge rst_n)
        if (!rst_n) begin
            led_reg   <= '0;
            tube_reg  <= '0;
            tube2_reg <= '0;
        end else if (cpu_we) begin
            case (addr)
                ADDR_TUBE:  tube_reg  <= cpu_wdata;
                ADDR_TUBE2: tube2_reg <= cpu_wdata[3:0];
                ADDR_LED:   led_reg   <= cpu_wdata;
                default: ;
            endcase
        end

    always_comb begin
        cpu_rdata = '0;
        case (addr)
            ADDR_UART_DATA: cpu_rdata = {24'b0, rx_data};
            ADDR_UART_STAT: begin
                cpu_rdata[STAT_TX_READY] = tx_ready;
                cpu_rdata[STAT_RX_VALID] = rx_valid;
            end
            ADDR_DIP_LO:    cpu_rdata = dip_s[31:0];
            ADDR_DIP_HI:    cpu_rdata = dip_s[63:32];
            ADDR_KEY:       cpu_rdata = {24'b0, key_s};
            ADDR_TUBE:      cpu_rdata = tube_reg;
            ADDR_TUBE2:     cpu_rdata = {28'b0, tube2_reg};
            ADDR_LED:       cpu_rdata = led_reg;
            default: ;
        endcase
    end

    assign hw_int    = {2'b00, |key_s, rx_valid, 2'b00};
    assign led_light = ~led_reg;

    logic [SW-1:0] scan_cnt;
    logic [1:0]    digit;
    always_ff @(posedge clk_in or negedge rst_n)
        if (!rst_n) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            digit    <= digit + 1'b1;
        end else
            scan_cnt <= scan_cnt + 1'b1;

    // Digit i of each group shows nibble i of its half of tube_reg.
    assign digital_tube_sel0 = 4'b0001 << digit;
    assign digital_tube_sel1 = 4'b0001 << digit;
    assign digital_tube_sel2 = 1'b1;
    assign digital_tube0 = hex_seg(tube_reg[{digit, 2'b00} +: 4]);
    assign digital_tube1 = hex_seg(tube_reg[{1'b1, digit, 2'b00} +: 4]);
    assign digital_tube2 = hex_seg(tube2_reg);

    logic unused_ok;
    assign unused_ok = ^cpu_addr[31:16];
endmodule

// File: tb/tb_mips_soc.sv
// Directed bench for mips_soc: drives the core's bus by forcing the bridge nets
// and checks GPIO, tubes and UART against hand-computed values.
module tb_mips_soc;
    localparam int N   = 16;  // 1 MHz / 62.5 kBd
    localparam int DIV = 10;  // 1 MHz / 100 kHz

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sys_rstn, uart_rxd;
    logic [7:0]  dip0, dip1, dip2, dip3, dip4, dip5, dip6, dip7, user_key;
    logic [3:0]  sel0, sel1;
    logic        sel2, uart_txd;
    logic [7:0]  tube0, tube1, tube2;
    logic [31:0] led_light;

    mips_soc #(.CLK_FREQ(1_000_000), .BAUD(62_500), .SCAN_HZ(100_000)) dut (
        .clk_in(clk), .sys_rstn(sys_rstn),
        .dip_switch0(dip0), .dip_switch1(dip1), .dip_switch2(dip2), .dip_switch3(dip3),
        .dip_switch4(dip4), .dip_switch5(dip5), .dip_switch6(dip6), .dip_switch7(dip7),
        .user_key(user_key), .uart_rxd(uart_rxd),
        .digital_tube_sel0(sel0), .digital_tube_sel1(sel1), .digital_tube_sel2(sel2),
        .digital_tube0(tube0), .digital_tube1(tube1), .digital_tube2(tube2),
        .led_light(led_light), .uart_txd(uart_txd)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] bus_addr, bus_wdata, rd;
    logic        bus_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_bus(input logic [31:0] a, input logic [31:0] d, input logic we);
        bus_addr = a; bus_wdata = d; bus_we = we;
        force dut.cpu_addr  = bus_addr;
        force dut.cpu_wdata = bus_wdata;
        force dut.cpu_we    = bus_we;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        drive_bus(a, d, 1'b1);
        @(posedge clk);
        #1 drive_bus(32'h0, 32'h0, 1'b0);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        drive_bus(a, 32'h0, 1'b0);
        #1 d = dut.cpu_rdata;
        @(posedge clk);
        #1 drive_bus(32'h0, 32'h0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) uart_rxd = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (N) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (N) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    task automatic wait_sel(input logic [3:0] exp, input int limit, output int cyc);
        cyc = 0;
        while (sel0 !== exp && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    logic [7:0] seg_lo [4];
    logic [7:0] seg_hi [4];
    logic [9:0] frame;
    logic [3:0] oh;
    int cyc;

    initial begin
        seg_lo = '{8'h80, 8'hF8, 8'h82, 8'h92};  // 8,7,6,5
        seg_hi = '{8'h99, 8'hB0, 8'hA4, 8'hF9};  // 4,3,2,1
        sys_rstn = 1'b0; uart_rxd = 1'b1; user_key = '0;
        {dip0, dip1, dip2, dip3, dip4, dip5, dip6, dip7} = '0;
        drive_bus(32'h0, 32'h0, 1'b0);

        repeat (3) @(negedge clk);
        check("rst_led", led_light, 32'hFFFFFFFF);
        check("rst_txd", {31'b0, uart_txd}, 32'h1);
        check("rst_tube0", {24'b0, tube0}, 32'hC0);
        check("rst_tube1", {24'b0, tube1}, 32'hC0);
        check("rst_tube2", {24'b0, tube2}, 32'hC0);
        check("rst_sel0", {28'b0, sel0}, 32'h1);
        check("rst_sel2", {31'b0, sel2}, 32'h1);
        check("rst_hwint", {26'b0, dut.hw_int}, 32'h0);

        @(negedge clk) sys_rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Switches
        dip0 = 8'h01; dip4 = 8'h01;
        repeat (3) @(negedge clk);
        bus_read(32'h7F2C, rd); check("dip_lo_1", rd, 32'h00000001);
        bus_read(32'h7F30, rd); check("dip_hi_1", rd, 32'h00000001);
        {dip3, dip2, dip1, dip0} = 32'h44332211;
        {dip7, dip6, dip5, dip4} = 32'h88776655;
        repeat (3) @(negedge clk);
        bus_read(32'h7F2C, rd); check("dip_lo_2", rd, 32'h44332211);
        bus_read(32'h7F30, rd); check("dip_hi_2", rd, 32'h88776655);

        // Keys: two-flop latency to the interrupt
        @(negedge clk) user_key = 8'h01;
        @(negedge clk) check("key_int_1cyc", {26'b0, dut.hw_int}, 32'h0);
        @(negedge clk) check("key_int_2cyc", {26'b0, dut.hw_int}, 32'h8);
        bus_read(32'h7F34, rd); check("key_rd_01", rd, 32'h00000001);
        user_key = 8'h80;
        repeat (3) @(negedge clk);
        bus_read(32'h7F34, rd); check("key_rd_80", rd, 32'h00000080);
        check("key_int_80", {26'b0, dut.hw_int}, 32'h8);
        user_key = 8'h00;
        repeat (3) @(negedge clk);
        check("key_int_clr", {26'b0, dut.hw_int}, 32'h0);

        // LEDs and unmapped space
        bus_write(32'h7F40, 32'h0000000F);
        check("led_out", led_light, 32'hFFFFFFF0);
        bus_read(32'h7F40, rd); check("led_rd", rd, 32'h0000000F);
        bus_write(32'h7F44, 32'hFFFFFFFF);
        bus_read(32'h7F44, rd); check("unmapped_rd", rd, 32'h0);
        check("led_after_unmapped", led_light, 32'hFFFFFFF0);

        // Tubes
        bus_write(32'h7F38, 32'h12345678);
        bus_read(32'h7F38, rd); check("tube_rd", rd, 32'h12345678);
        bus_write(32'h7F3C, 32'hFFFFFFFA);
        bus_read(32'h7F3C, rd); check("tube2_rd", rd, 32'h0000000A);
        check("tube2_seg", {24'b0, tube2}, 32'h88);
        @(negedge clk);
        wait_sel(4'b1000, 6 * DIV, cyc);
        wait_sel(4'b0001, 2 * DIV, cyc);
        check("scan_sel0_d0", {28'b0, sel0}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            oh = 4'b0001 << i;
            check($sformatf("scan_tube0_d%0d", i), {24'b0, tube0}, {24'b0, seg_lo[i]});
            check($sformatf("scan_tube1_d%0d", i), {24'b0, tube1}, {24'b0, seg_hi[i]});
            check($sformatf("scan_sel1_d%0d", i), {28'b0, sel1}, {28'b0, oh});
            if (i < 3) begin
                oh = 4'b0001 << (i + 1);
                wait_sel(oh, 2 * DIV, cyc);
                check($sformatf("scan_sel0_d%0d", i + 1), {28'b0, sel0}, {28'b0, oh});
                check($sformatf("scan_period_d%0d", i + 1), cyc, DIV);
            end
        end

        // UART TX, with a second write while busy that must be dropped
        frame = {1'b1, 8'h55, 1'b0};
        bus_write(32'h7F10, 32'h00000055);
        bus_write(32'h7F10, 32'h000000FF);
        bus_read(32'h7F14, rd); check("tx_busy_stat", rd, 32'h0);
        repeat (N / 2 - 2) @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            check($sformatf("tx_bit%0d", b), {31'b0, uart_txd}, {31'b0, frame[b]});
            if (b < 9) repeat (N) @(negedge clk);
        end
        bus_read(32'h7F14, rd); check("tx_stop_stat", rd, 32'h0);
        repeat (N) @(negedge clk);
        bus_read(32'h7F14, rd); check("tx_done_stat", rd, 32'h1);
        check("tx_idle_txd", {31'b0, uart_txd}, 32'h1);

        // UART RX
        send_byte(8'hA3, 1'b1);
        repeat (2) @(negedge clk);
        check("rx_int", {26'b0, dut.hw_int}, 32'h4);
        bus_read(32'h7F14, rd); check("rx_stat_valid", rd, 32'h3);
        bus_read(32'h7F10, rd); check("rx_data_a3", rd, 32'h000000A3);
        bus_read(32'h7F14, rd); check("rx_stat_clr", rd, 32'h1);
        check("rx_int_clr", {26'b0, dut.hw_int}, 32'h0);
        send_byte(8'h5A, 1'b0);
        repeat (2 * N) @(negedge clk);
        bus_read(32'h7F14, rd); check("rx_bad_stop", rd, 32'h1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (3) @(negedge clk);
        bus_read(32'h7F10, rd); check("rx_overwrite", rd, 32'h00000022);

        // Reset in the middle of a TX frame
        bus_write(32'h7F10, 32'h00000000);
        repeat (3 * N) @(negedge clk);
        check("tx_mid_frame", {31'b0, uart_txd}, 32'h0);
        sys_rstn = 1'b0;
        #1;
        check("rst_abort_txd", {31'b0, uart_txd}, 32'h1);
        check("rst_abort_led", led_light, 32'hFFFFFFFF);
        check("rst_abort_tube0", {24'b0, tube0}, 32'hC0);
        repeat (2) @(negedge clk);
        sys_rstn = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(32'h7F14, rd); check("post_rst_stat", rd, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
